matrix_result_streamer: RTL and testbench



---
 rtl/matrix_pkg.sv | 19 +
 rtl/matrix_result_streamer_if.sv | 45 ++++
 rtl/matrix_index_counter.sv | 53 +++++
 rtl/matrix_result_streamer.sv | 116 +++++++++++
 tb/tb_matrix_result_streamer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks: streamer state encoding,
// default matrix geometry and the index-width helper.
package matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_STREAM = 2'b01,
    S_DONE   = 2'b11
  } state_e;

  localparam int MATRIX_N      = 8;
  localparam int MATRIX_DATA_W = 32;

  // A 1x1 matrix still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Load, stream and status signals of matrix_result_streamer.
// RESULT_STREAMER_CHECKSUM_EN adds the running checksum signal.
interface matrix_result_streamer_if
  import matrix_pkg::*;
#(
  parameter int N      = MATRIX_N,
  parameter int DATA_W = MATRIX_DATA_W
);
  localparam int IDX_W = idx_width(N);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_row;
  logic [IDX_W-1:0]  wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [DATA_W-1:0] value;
  logic              value_stb;
  logic              value_ack;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic              busy;
  logic              done;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    input  wr_en, wr_row, wr_col, wr_data, start, value_ack,
    output value, value_stb, i, j, busy, done, checksum
  );
  modport slave (
    output wr_en, wr_row, wr_col, wr_data, start, value_ack,
    input  value, value_stb, i, j, busy, done, checksum
  );
`else
  modport master (
    input  wr_en, wr_row, wr_col, wr_data, start, value_ack,
    output value, value_stb, i, j, busy, done
  );
  modport slave (
    output wr_en, wr_row, wr_col, wr_data, start, value_ack,
    input  value, value_stb, i, j, busy, done
  );
`endif

endinterface

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over an N x N matrix; wraps to (0,0) after the
// last element. Shared by the result streamer and the file writer.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter  int N     = MATRIX_N,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/matrix_result_streamer.sv
// Holds the N x N result matrix and streams it row-major over stb/ack with (i,j).
// Optional RESULT_STREAMER_CHECKSUM_EN adds a modulo-2^DATA_W sum of streamed values.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int N      = MATRIX_N,
  parameter int DATA_W = MATRIX_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matrix_result_streamer_if.master bus
);

  localparam int              IDX_W = idx_width(N);
  localparam logic [IDX_W:0]  N_EXT = (IDX_W + 1)'(N);

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [N][N];
  logic [IDX_W-1:0]  row, col;
  logic [DATA_W-1:0] rd_data;
  logic              last, stb, xfer, wr_ok, cnt_clear, cnt_adv;

  assign stb   = (state_q == S_STREAM);
  assign xfer  = stb & bus.value_ack;
  // Loads are only honoured while not streaming, and out-of-range addresses are dropped.
  assign wr_ok = bus.wr_en && !stb
              && ({1'b0, bus.wr_row} < N_EXT) && ({1'b0, bus.wr_col} < N_EXT);

  // Storage is data only and deliberately carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  assign rd_data = mem_q[row][col];

  matrix_index_counter #(.N(N)) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (cnt_clear),
    .advance_i (cnt_adv),
    .row_o     (row),
    .col_o     (col),
    .last_o    (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_STREAM;
          done_d    = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          cnt_adv = 1'b1;
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.value_stb = stb;
  assign bus.busy      = stb;
  assign bus.done      = done_q;
  assign bus.i         = row;
  assign bus.j         = col;
  assign bus.value     = stb ? rd_data : '0;

`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE) && bus.start) begin
      csum_d = '0;
    end else if (xfer) begin
      csum_d = csum_q + rd_data;
    end
  end

  assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: N=2 and N=1 instances, table vectors plus
// randomized streams checked against a row-major model of the loaded matrix.
module tb_matrix_result_streamer;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_result_streamer_if #(.N(2), .DATA_W(DW)) bus_a ();
  matrix_result_streamer_if #(.N(1), .DATA_W(DW)) bus_b ();

  matrix_result_streamer #(.N(2), .DATA_W(DW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  matrix_result_streamer #(.N(1), .DATA_W(DW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_a [2][2];

  typedef struct {
    logic        start;
    logic        ack;
    logic        stb;
    logic        i;
    logic        j;
    logic [31:0] value;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_a(input int r, input int c, input logic [DW-1:0] d);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_row  = r[0];
    bus_a.wr_col  = c[0];
    bus_a.wr_data = d;
    ref_a[r][c]   = d;
    tick();
    bus_a.wr_en = 1'b0;
  endtask

  task automatic start_a(input bit with_wr, input int r, input int c, input logic [DW-1:0] d);
    bus_a.start = 1'b1;
    if (with_wr) begin
      bus_a.wr_en   = 1'b1;
      bus_a.wr_row  = r[0];
      bus_a.wr_col  = c[0];
      bus_a.wr_data = d;
      ref_a[r][c]   = d;
    end
    tick();
    bus_a.start = 1'b0;
    bus_a.wr_en = 1'b0;
  endtask

  // ack_mode: 0 always, 1 one cycle in three, 2 random. poke drives start and a
  // write to (0,1) throughout the stream; both must be ignored.
  task automatic stream_a(input int ack_mode, input bit poke);
    int k = 0;
    int cyc = 0;
    logic ack;
    logic [DW-1:0] sum = '0;
    while (bus_a.value_stb !== 1'b1 && cyc < 5) begin
      tick();
      cyc++;
    end
    chk("stb_rise", 32'(bus_a.value_stb), 32'd1);
`ifdef RESULT_STREAMER_CHECKSUM_EN
    chk("csum_cleared", bus_a.checksum, 32'd0);
`endif
    cyc = 0;
    while (k < 4 && cyc < 100) begin
      chk("s_stb",   32'(bus_a.value_stb), 32'd1);
      chk("s_busy",  32'(bus_a.busy), 32'd1);
      chk("s_i",     32'(bus_a.i), 32'(k / 2));
      chk("s_j",     32'(bus_a.j), 32'(k % 2));
      chk("s_value", bus_a.value, ref_a[k / 2][k % 2]);
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 3 == 2);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      bus_a.value_ack = ack;
      bus_a.start     = poke & cyc[0];
      bus_a.wr_en     = poke;
      bus_a.wr_row    = 1'b0;
      bus_a.wr_col    = 1'b1;
      bus_a.wr_data   = 32'hDEAD;
      if (ack) begin
        sum = sum + ref_a[k / 2][k % 2];
        k++;
      end
      tick();
      cyc++;
    end
    if (k < 4) chk("stream_timeout", 32'(k), 32'd4);
    bus_a.value_ack = 1'b0;
    bus_a.start     = 1'b0;
    bus_a.wr_en     = 1'b0;
    chk("d_stb",   32'(bus_a.value_stb), 32'd0);
    chk("d_busy",  32'(bus_a.busy), 32'd0);
    chk("d_done",  32'(bus_a.done), 32'd1);
    chk("d_i",     32'(bus_a.i), 32'd0);
    chk("d_j",     32'(bus_a.j), 32'd0);
    chk("d_value", bus_a.value, 32'd0);
`ifdef RESULT_STREAMER_CHECKSUM_EN
    chk("d_csum", bus_a.checksum, sum);
`endif
    tick();
    chk("idle_done", 32'(bus_a.done), 32'd1);
    chk("idle_busy", 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_row = '0; bus_a.wr_col = '0; bus_a.wr_data = '0;
    bus_a.start = 1'b0; bus_a.value_ack = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_row = '0; bus_b.wr_col = '0; bus_b.wr_data = '0;
    bus_b.start = 1'b0; bus_b.value_ack = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1};

    repeat (3) tick();
    chk("rst_stb",   32'(bus_a.value_stb), 32'd0);
    chk("rst_busy",  32'(bus_a.busy), 32'd0);
    chk("rst_done",  32'(bus_a.done), 32'd0);
    chk("rst_i",     32'(bus_a.i), 32'd0);
    chk("rst_j",     32'(bus_a.j), 32'd0);
    chk("rst_value", bus_a.value, 32'd0);
    chk("rst_b_stb", 32'(bus_b.value_stb), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream of {1,2,3,4}
    wr_a(0, 0, 32'd1); wr_a(0, 1, 32'd2); wr_a(1, 0, 32'd3); wr_a(1, 1, 32'd4);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("tbl%0d_stb", k),   32'(bus_a.value_stb), 32'(tbl[k].stb));
      chk($sformatf("tbl%0d_i", k),     32'(bus_a.i), 32'(tbl[k].i));
      chk($sformatf("tbl%0d_j", k),     32'(bus_a.j), 32'(tbl[k].j));
      chk($sformatf("tbl%0d_value", k), bus_a.value, tbl[k].value);
      chk($sformatf("tbl%0d_busy", k),  32'(bus_a.busy), 32'(tbl[k].busy));
      chk($sformatf("tbl%0d_done", k),  32'(bus_a.done), 32'(tbl[k].done));
      bus_a.start     = tbl[k].start;
      bus_a.value_ack = tbl[k].ack;
      tick();
    end
    bus_a.start = 1'b0;
    bus_a.value_ack = 1'b0;

    // Stalled consumer
    start_a(1'b0, 0, 0, '0);
    stream_a(1, 1'b0);

    // Writes and start while busy are ignored; write with start commits
    start_a(1'b0, 0, 0, '0);
    stream_a(0, 1'b1);
    start_a(1'b0, 0, 0, '0);
    stream_a(0, 1'b0);
    start_a(1'b1, 0, 1, 32'h1234);
    stream_a(0, 1'b0);

    // Reset after two transfers
    start_a(1'b0, 0, 0, '0);
    bus_a.value_ack = 1'b1;
    tick(); tick();
    chk("mid_i", 32'(bus_a.i), 32'd1);
    bus_a.value_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mrst_stb",  32'(bus_a.value_stb), 32'd0);
    chk("mrst_i",    32'(bus_a.i), 32'd0);
    chk("mrst_j",    32'(bus_a.j), 32'd0);
    chk("mrst_done", 32'(bus_a.done), 32'd0);
    chk("mrst_busy", 32'(bus_a.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    start_a(1'b0, 0, 0, '0);
    stream_a(2, 1'b0);

    // Randomized contents and ack patterns
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 4; w++) begin
        wr_a(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), $urandom);
      end
      start_a(1'b0, 0, 0, '0);
      stream_a(2, 1'($urandom_range(0, 1)));
    end

`ifdef RESULT_STREAMER_CHECKSUM_EN
    wr_a(0, 0, 32'hFFFF_FFFF); wr_a(0, 1, 32'd1); wr_a(1, 0, 32'd2); wr_a(1, 1, 32'd3);
    start_a(1'b0, 0, 0, '0);
    stream_a(0, 1'b0);
    chk("csum_wrap", bus_a.checksum, 32'd5);
`endif

    // N=1: out-of-range loads dropped, single transfer then done
    bus_b.wr_en = 1'b1; bus_b.wr_row = 1'b0; bus_b.wr_col = 1'b0; bus_b.wr_data = 32'h55;
    tick();
    bus_b.wr_row = 1'b1; bus_b.wr_col = 1'b0; bus_b.wr_data = 32'hBAD;
    tick();
    bus_b.wr_row = 1'b0; bus_b.wr_col = 1'b1; bus_b.wr_data = 32'hBAD;
    tick();
    bus_b.wr_en = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    chk("n1_stb",   32'(bus_b.value_stb), 32'd1);
    chk("n1_value", bus_b.value, 32'h55);
    chk("n1_i",     32'(bus_b.i), 32'd0);
    chk("n1_j",     32'(bus_b.j), 32'd0);
    bus_b.value_ack = 1'b1;
    tick();
    bus_b.value_ack = 1'b0;
    chk("n1_d_stb",  32'(bus_b.value_stb), 32'd0);
    chk("n1_d_done", 32'(bus_b.done), 32'd1);
    chk("n1_d_busy", 32'(bus_b.busy), 32'd0);
    tick();
    chk("n1_idle_done", 32'(bus_b.done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
